// File: rtl/piso_serializer_if.sv
// Load and serial-out handshake bundle for piso_serializer.
// The master side feeds words and drives Sout_Ready; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] Din;
    logic             Load_Valid;
    logic             Load_Ready;
    logic             Sout;
    logic             Sout_Valid;
    logic             Sout_Ready;
    logic             Sout_First;
    logic             Sout_Last;
    logic             Busy;
    logic             Done;

    modport master (
        output Din, Load_Valid, Sout_Ready,
        input  Load_Ready, Sout, Sout_Valid, Sout_First, Sout_Last, Busy, Done
    );

    modport slave (
        input  Din, Load_Valid, Sout_Ready,
        output Load_Ready, Sout, Sout_Valid, Sout_First, Sout_Last, Busy, Done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with load and serial valid/ready handshakes,
// first/last framing markers and a one-cycle completion pulse.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    piso_serializer_if.slave  bus
);
    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             done_r, done_nxt;
    logic             busy;
    logic             out_bit;

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    // Next-state: load in IDLE, shift on each accepted bit, return after the last one
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Load_Valid) begin
                    shreg_nxt = bus.Din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.Sout_Ready) begin
                    if (cnt == LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        shreg_nxt = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                                     : {1'b0, shreg[WIDTH-1:1]};
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    assign busy    = (state == SHIFT);
    assign out_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    // Handshake and framing outputs decoded straight from the registers
    assign bus.Load_Ready = (state == IDLE);
    assign bus.Busy       = busy;
    assign bus.Sout_Valid = busy;
    assign bus.Sout       = busy & out_bit;
    assign bus.Sout_First = busy & (cnt == '0);
    assign bus.Sout_Last  = busy & (cnt == LAST);
    assign bus.Done       = done_r;
endmodule
